uno_seq: RTL and testbench
==========================

// Module: uno_seq
// PURPOSE
//  Command sequencer (initiator) for the uno PE, which is a unified MAC/div/exp/log datapath.
//  Accepts one command per op, then drives the PE's cycle controls:
//   - op, X, Y, Z, coeff
//   - first_cycle, last_cycle, acc_en
//  For op 00 (MAC) it streams X/Y beats; for ops 01/10/11 it issues the N_TERMS coefficients.
//  It captures the PE result and returns it on a valid/ready port. It sits between the array
//  scheduler and one uno instance.
// PARAMETERS
//  MAC_BW    12  operand width; PE result width is 2*MAC_BW+4
//  N_TERMS    4  series terms for div/exp/log (>=2)
//  PE_LAT     1  cycles from the PE input to a registered out update
//  LEN_BW     8  width of the MAC beat-count field
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous reset, active-high
//  cmd_valid  in   1           command offered
//  cmd_ready  out  1           command accepted when valid&ready
//  cmd_op     in   2           00 mac, 01 div, 10 exp, 11 log
//  cmd_x      in   MAC_BW      X operand (non-MAC ops)
//  cmd_y      in   MAC_BW      Y operand (div only)
//  cmd_z      in   2*MAC_BW    MAC initial accumulator
//  cmd_len    in   LEN_BW      MAC beat count (0 treated as 1)
//  dat_valid  in   1           MAC X/Y beat offered
//  dat_ready  out  1           beat consumed when valid&ready
//  dat_x      in   MAC_BW      MAC beat X
//  dat_y      in   MAC_BW      MAC beat Y
//  pe_op      out  2           to PE op
//  pe_x       out  MAC_BW      to PE X
//  pe_y       out  MAC_BW      to PE Y
//  pe_z       out  2*MAC_BW    to PE Z
//  pe_coeff   out  MAC_BW      to PE coeff
//  pe_first   out  1           to PE first cycle
//  pe_last    out  1           to PE last_cycle
//  pe_acc_en  out  1           to PE acc_en
//  pe_out     in   2*MAC_BW+4  from PE out
//  res_valid  out  1           result held until res_ready
//  res_ready  in   1           result consumer ready
//  res_data   out  2*MAC_BW+4  captured pe_out
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; counters 0.
//   - Reset mid-operation aborts the command; the partial result is discarded, no res_valid.
//  FSM states: IDLE, ISSUE, DRAIN, HOLD.
//  IDLE:
//   - cmd_ready=1; on handshake, latch op/x/y/z/len, clear term counter k, go to ISSUE.
//   - pe_op is held at the latched op from acceptance until the return to IDLE.
//  ISSUE, non-MAC ops:
//   - One term per cycle, k=0..N_TERMS-1; never stalls.
//   - Drive pe_x=X, pe_y=Y, pe_coeff=rom(op,k), pe_first=(k==0), pe_last=(k==N_TERMS-1).
//   - After k=N_TERMS-1, go to DRAIN.
//  ISSUE, MAC op:
//   - dat_ready=1; each accepted beat drives pe_x/pe_y=dat_x/dat_y.
//   - Beat 0 has pe_acc_en=0 (uses pe_z=Z); later beats have acc_en=1.
//   - Cycle with no beat (dat_valid=0): drive pe_x=0, pe_y=0, acc_en=1 so the PE accumulator
//     holds. Such a cycle does not count as a beat.
//   - After beat max(len,1)-1 is accepted, dat_ready drops the next cycle; go to DRAIN.
//  DRAIN:
//   - Wait PE_LAT cycles with inputs held neutral: MAC uses x=y=0, acc_en=1.
//   - Non-MAC uses the first/last deasserts, and pe_out must be sampled before a further update.
//   - Then capture pe_out into res_data; res_valid=1; go to HOLD.
//  HOLD:
//   - res_data stable while res_valid & !res_ready.
//   - On res_ready, go to IDLE the next cycle; cmd_ready is 0 during HOLD (no overlap).
//  Latency:
//   - Non-MAC: accept -> res_valid = N_TERMS+PE_LAT+1 cycles.
//   - MAC: that many cycles plus beats and stalls.
//  Width rules: the accumulator lives in the PE, so no arithmetic in this block except the
//  counters. k saturates and never wraps.
//  Simultaneous events: dat_valid outside ISSUE/MAC is ignored (dat_ready=0).
// STRUCTURE
//  Package uno_pkg holds:
//   - op_e enum {OP_MAC, OP_DIV, OP_EXP, OP_LOG}
//   - MAC_BW, OUT_BW=2*MAC_BW+4
//   - state_e
//  Sub-module uno_coeff_rom: combinational (op, k) -> MAC_BW coefficient table, N_TERMS entries
//  per non-MAC op.
// TESTING
//  1. Reset held 3 cycles -> every output 0; cmd_ready=1 the first cycle after release.
//  2. MAC with z=10, len=3, beats (2,3),(4,5),(1,1) back-to-back, against a PE model ->
//     res_data=37; acc_en sequence 0,1,1.
//  3. Same as 2 with dat_valid low 2 cycles between beats -> res_data=37; neutral x=y=0,
//     acc_en=1 on stall cycles.
//  4. exp with x=0x180 -> pe_first only at k=0; pe_last only at k=3; pe_coeff=rom(10,0..3) in
//     order; res_valid 6 cycles after accept.
//  5. Non-MAC result with res_ready=0 for 5 cycles -> res_data stable; cmd_ready=0; IDLE one
//     cycle after the ready handshake.
//  6. rst at k=2 of log -> no res_valid; all outputs 0. The next MAC with len=0 takes exactly 1
//     beat: X*Y+Z.

Source files
------------

// File: rtl/uno_pkg.sv
// Shared types and widths for the uno PE command sequencer.
package uno_pkg;

   localparam int MAC_BW = 12;
   localparam int OUT_BW = 2*MAC_BW + 4;

   typedef enum logic [1:0] {
      OP_MAC = 2'b00,
      OP_DIV = 2'b01,
      OP_EXP = 2'b10,
      OP_LOG = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_DRAIN = 2'b10,
      ST_HOLD  = 2'b11
   } state_e;

endpackage

// File: rtl/uno_coeff_rom.sv
// Series coefficient table for the non-MAC ops, fixed point Q2.10
// (0x400 = 1.0), two's complement for negative terms.
//   div : 1/(1+x)  -> 1, -1, 1, -1
//   exp : e^x      -> 1, 1, 1/2, 1/6
//   log : ln(1+x)  -> 1, -1/2, 1/3, -1/4
module uno_coeff_rom
   import uno_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int KW      = 2
) (
   input  op_e               i_op,
   input  logic [KW-1:0]     i_k,
   output logic [MAC_BW-1:0] o_coeff
);

   // table lookup; terms beyond the table or for MAC read as zero
   always_comb begin
      o_coeff = '0;
      if (int'(i_k) < N_TERMS) begin
         case (i_op)
            OP_DIV: begin
               case (int'(i_k))
                  0:       o_coeff = 12'h400;
                  1:       o_coeff = 12'hC00;
                  2:       o_coeff = 12'h400;
                  3:       o_coeff = 12'hC00;
                  default: o_coeff = '0;
               endcase
            end
            OP_EXP: begin
               case (int'(i_k))
                  0:       o_coeff = 12'h400;
                  1:       o_coeff = 12'h400;
                  2:       o_coeff = 12'h200;
                  3:       o_coeff = 12'h0AB;
                  default: o_coeff = '0;
               endcase
            end
            OP_LOG: begin
               case (int'(i_k))
                  0:       o_coeff = 12'h400;
                  1:       o_coeff = 12'hE00;
                  2:       o_coeff = 12'h155;
                  3:       o_coeff = 12'hF00;
                  default: o_coeff = '0;
               endcase
            end
            default: o_coeff = '0;
         endcase
      end
   end

endmodule

// File: rtl/uno_seq.sv
// Command sequencer for one uno PE: accepts a command, drives the PE cycle
// controls (MAC beat stream or series coefficients), captures the result
// and returns it on a valid/ready port.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | cmd_ready high, waiting for a command
//  ST_ISSUE | MAC: consuming X/Y beats; others: one series term per cycle
//  ST_DRAIN | PE inputs neutral for PE_LAT cycles, then capture pe_out
//  ST_HOLD  | res_valid high until res_ready
module uno_seq
   import uno_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int PE_LAT  = 1,
   parameter int LEN_BW  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [MAC_BW-1:0]   cmd_x,
   input  logic [MAC_BW-1:0]   cmd_y,
   input  logic [2*MAC_BW-1:0] cmd_z,
   input  logic [LEN_BW-1:0]   cmd_len,
   input  logic                dat_valid,
   output logic                dat_ready,
   input  logic [MAC_BW-1:0]   dat_x,
   input  logic [MAC_BW-1:0]   dat_y,
   output logic [1:0]          pe_op,
   output logic [MAC_BW-1:0]   pe_x,
   output logic [MAC_BW-1:0]   pe_y,
   output logic [2*MAC_BW-1:0] pe_z,
   output logic [MAC_BW-1:0]   pe_coeff,
   output logic                pe_first,
   output logic                pe_last,
   output logic                pe_acc_en,
   input  logic [OUT_BW-1:0]   pe_out,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [OUT_BW-1:0]   res_data
);

   localparam int KW = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
   localparam int DW = (PE_LAT > 2) ? $clog2(PE_LAT) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);
   localparam logic [DW-1:0] D_LOAD = DW'(PE_LAT - 1);

   state_e                r_state;
   state_e                w_next;
   op_e                   r_op;
   logic [MAC_BW-1:0]     r_x;
   logic [MAC_BW-1:0]     r_y;
   logic [2*MAC_BW-1:0]   r_z;
   logic [LEN_BW-1:0]     r_rem;     // beats still to accept after the current one
   logic                  r_beat0;   // next accepted beat is the first one
   logic [KW-1:0]         r_k;
   logic [DW-1:0]         r_drn;
   logic [OUT_BW-1:0]     r_res;
   logic [MAC_BW-1:0]     w_rom_coeff;
   logic                  w_is_mac;

   assign w_is_mac = (r_op == OP_MAC);

   uno_coeff_rom #(
      .N_TERMS (N_TERMS),
      .KW      (KW)
   ) u_rom (
      .i_op    (r_op),
      .i_k     (r_k),
      .o_coeff (w_rom_coeff)
   );

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (w_is_mac) begin
               if (dat_valid && (r_rem == '0)) w_next = ST_DRAIN;
            end else if (r_k == K_LAST) begin
               w_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (r_drn == '0) w_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // state register, command latch, term/beat/drain counters, result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_MAC;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_rem   <= '0;
         r_beat0 <= 1'b0;
         r_k     <= '0;
         r_drn   <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_op    <= op_e'(cmd_op);
                  r_x     <= cmd_x;
                  r_y     <= cmd_y;
                  r_z     <= cmd_z;
                  r_rem   <= (cmd_len == '0) ? '0 : cmd_len - 1'b1;
                  r_beat0 <= 1'b1;
                  r_k     <= '0;
               end
            end
            ST_ISSUE: begin
               if (w_is_mac) begin
                  if (dat_valid) begin
                     r_beat0 <= 1'b0;
                     if (r_rem != '0) r_rem <= r_rem - 1'b1;
                  end
               end else if (r_k != K_LAST) begin
                  r_k <= r_k + 1'b1;
               end
               if (w_next == ST_DRAIN) r_drn <= D_LOAD;
            end
            ST_DRAIN: begin
               // pe_out already reflects the last issued input; grab it
               // before the PE sees another update
               if (r_drn != '0) r_drn <= r_drn - 1'b1;
               else             r_res <= pe_out;
            end
            default: ;
         endcase
      end
   end

   // PE and handshake outputs; everything forced low while rst is high
   always_comb begin
      cmd_ready = 1'b0;
      dat_ready = 1'b0;
      pe_op     = 2'b00;
      pe_x      = '0;
      pe_y      = '0;
      pe_z      = '0;
      pe_coeff  = '0;
      pe_first  = 1'b0;
      pe_last   = 1'b0;
      pe_acc_en = 1'b0;
      res_valid = 1'b0;
      res_data  = r_res;
      if (r_state != ST_IDLE) pe_op = r_op;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
         end
         ST_ISSUE: begin
            if (w_is_mac) begin
               dat_ready = 1'b1;
               pe_z      = r_z;
               if (dat_valid) begin
                  pe_x      = dat_x;
                  pe_y      = dat_y;
                  pe_acc_en = !r_beat0;
               end else begin
                  // stall: zero product keeps the accumulator unchanged
                  pe_acc_en = 1'b1;
               end
            end else begin
               pe_x     = r_x;
               pe_y     = r_y;
               pe_coeff = w_rom_coeff;
               pe_first = (r_k == '0);
               pe_last  = (r_k == K_LAST);
            end
         end
         ST_DRAIN: begin
            if (w_is_mac) begin
               pe_z      = r_z;
               pe_acc_en = 1'b1;
            end
         end
         ST_HOLD: begin
            res_valid = 1'b1;
         end
         default: ;
      endcase
      if (rst) begin
         cmd_ready = 1'b0;
         dat_ready = 1'b0;
         pe_op     = 2'b00;
         pe_x      = '0;
         pe_y      = '0;
         pe_z      = '0;
         pe_coeff  = '0;
         pe_first  = 1'b0;
         pe_last   = 1'b0;
         pe_acc_en = 1'b0;
         res_valid = 1'b0;
         res_data  = '0;
      end
   end

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq with a behavioural PE model on pe_* outputs.
module tb_uno_seq;
   import uno_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [11:0] cmd_x = '0;
   logic [11:0] cmd_y = '0;
   logic [23:0] cmd_z = '0;
   logic [7:0]  cmd_len = '0;
   logic        dat_valid = 1'b0;
   logic        dat_ready;
   logic [11:0] dat_x = '0;
   logic [11:0] dat_y = '0;
   logic [1:0]  pe_op;
   logic [11:0] pe_x;
   logic [11:0] pe_y;
   logic [23:0] pe_z;
   logic [11:0] pe_coeff;
   logic        pe_first;
   logic        pe_last;
   logic        pe_acc_en;
   logic [27:0] pe_out;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [27:0] res_data;

   int n_pass = 0;
   int n_tot  = 0;

   uno_seq #(.N_TERMS(4), .PE_LAT(1), .LEN_BW(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_len(cmd_len),
      .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_x(dat_x), .dat_y(dat_y),
      .pe_op(pe_op), .pe_x(pe_x), .pe_y(pe_y), .pe_z(pe_z), .pe_coeff(pe_coeff),
      .pe_first(pe_first), .pe_last(pe_last), .pe_acc_en(pe_acc_en),
      .pe_out(pe_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   // PE model, PE_LAT=1: MAC acc = Z + sum(x*y); series ops acc = x + sum(coeff)
   logic [27:0] pe_acc;
   assign pe_out = pe_acc;
   always @(posedge clk) begin
      if (rst) pe_acc <= '0;
      else if (pe_op == 2'b00) begin
         if (!pe_acc_en) pe_acc <= {4'b0, pe_z} + {16'b0, pe_x} * {16'b0, pe_y};
         else            pe_acc <= pe_acc + {16'b0, pe_x} * {16'b0, pe_y};
      end else if (pe_first) pe_acc <= {16'b0, pe_x} + {16'b0, pe_coeff};
      else                   pe_acc <= pe_acc + {16'b0, pe_coeff};
   end

   typedef struct {
      logic [1:0]  op;
      logic [11:0] x;
      logic [11:0] y;
      logic [47:0] coeffs;   // {c3,c2,c1,c0}
      logic [27:0] res;
      int          hold;
   } vec_t;

   vec_t        vt[4];
   logic [11:0] bx[8];
   logic [11:0] by[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   function automatic logic any_out();
      return |{cmd_ready, dat_ready, pe_op, pe_x, pe_y, pe_z, pe_coeff,
               pe_first, pe_last, pe_acc_en, res_valid, res_data};
   endfunction

   task automatic send_cmd(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y,
                           input logic [23:0] z, input logic [7:0] len);
      @(negedge clk);
      cmd_op = op; cmd_x = x; cmd_y = y; cmd_z = z; cmd_len = len;
      cmd_valid = 1'b1;
      #1 chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic finish_res(input logic [27:0] exp);
      int lat = 0;
      logic seen = 1'b0;
      while (!seen && lat < 30) begin
         @(negedge clk);
         lat++;
         if (res_valid) seen = 1'b1;
      end
      chk("res_valid_seen", seen, 1);
      chk("res_data", res_data, exp);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_res", {cmd_ready, res_valid}, 2'b10);
   endtask

   task automatic run_nonmac(input vec_t v);
      int   lat;
      logic seen;
      send_cmd(v.op, v.x, v.y, 24'h0, 8'h0);
      lat = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         lat++;
         chk("pe_first", pe_first, (k == 0));
         chk("pe_last", pe_last, (k == 3));
         chk("pe_coeff", pe_coeff, v.coeffs[k*12 +: 12]);
         chk("pe_xyop", {pe_op, pe_x, pe_y}, {v.op, v.x, v.y});
         if (k == 0) chk("issue_ready", {cmd_ready, dat_ready}, 2'b00);
      end
      seen = 1'b0;
      while (!seen && lat < 30) begin
         @(negedge clk);
         lat++;
         if (res_valid) seen = 1'b1;
      end
      chk("nonmac_latency", lat, 6);
      chk("nonmac_res", res_data, v.res);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk("hold_stable", {res_valid, cmd_ready, res_data}, {1'b1, 1'b0, v.res});
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_res", {cmd_ready, res_valid}, 2'b10);
   endtask

   task automatic run_mac(input logic [23:0] z, input logic [7:0] len, input int nb,
                          input int gap, input logic [27:0] exp);
      send_cmd(2'b00, 12'h0, 12'h0, z, len);
      for (int i = 0; i < nb; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               dat_valid = 1'b0;
               #1 chk("stall_neutral", {dat_ready, pe_acc_en, pe_x, pe_y}, {2'b11, 24'h0});
            end
         end
         @(negedge clk);
         dat_valid = 1'b1; dat_x = bx[i]; dat_y = by[i];
         #1;
         chk("beat_ready", dat_ready, 1);
         chk("beat_xy", {pe_x, pe_y}, {bx[i], by[i]});
         chk("beat_acc_en", pe_acc_en, (i != 0));
         if (i == 0) chk("beat0_z", pe_z, z);
      end
      @(negedge clk);
      dat_valid = 1'b0;
      #1 chk("drain_neutral", {dat_ready, pe_acc_en, pe_x, pe_y}, {2'b01, 24'h0});
      finish_res(exp);
   endtask

   initial begin
      logic seen;
      vt[0] = '{op: 2'b01, x: 12'h010, y: 12'h020, coeffs: 48'hC00_400_C00_400, res: 28'h0002010, hold: 0};
      vt[1] = '{op: 2'b10, x: 12'h180, y: 12'h000, coeffs: 48'h0AB_200_400_400, res: 28'h0000C2B, hold: 5};
      vt[2] = '{op: 2'b11, x: 12'h001, y: 12'h000, coeffs: 48'hF00_155_E00_400, res: 28'h0002256, hold: 0};
      vt[3] = '{op: 2'b10, x: 12'hFFF, y: 12'h000, coeffs: 48'h0AB_200_400_400, res: 28'h0001AAA, hold: 1};

      // reset held 3 cycles
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("reset_outputs_zero", any_out(), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_reset", cmd_ready, 1);
      dat_valid = 1'b1;
      #1 chk("dat_ignored_idle", dat_ready, 0);
      dat_valid = 1'b0;

      // series ops from the table
      for (int i = 0; i < 4; i++) run_nonmac(vt[i]);

      // MAC back-to-back: 10 + 2*3 + 4*5 + 1*1 = 37
      bx[0] = 12'd2; by[0] = 12'd3;
      bx[1] = 12'd4; by[1] = 12'd5;
      bx[2] = 12'd1; by[2] = 12'd1;
      run_mac(24'd10, 8'd3, 3, 0, 28'd37);
      // same with two stall cycles between beats
      run_mac(24'd10, 8'd3, 3, 2, 28'd37);

      // reset in the middle of a log op at k=2
      send_cmd(2'b11, 12'h003, 12'h000, 24'h0, 8'h0);
      repeat (3) @(negedge clk);
      chk("log_k2_coeff", pe_coeff, 12'h155);
      rst = 1'b1;
      #1 chk("midop_reset_zero", any_out(), 0);
      @(negedge clk);
      chk("midop_reset_zero2", any_out(), 0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      chk("no_res_after_abort", seen, 0);
      chk("idle_after_abort", cmd_ready, 1);

      // len=0 behaves as a single beat: 7*9 + 100 = 163
      bx[0] = 12'd7; by[0] = 12'd9;
      run_mac(24'd100, 8'd0, 1, 0, 28'd163);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
